// File: rtl/adc_sample_sched.sv
// rtl/adc_sample_sched.sv - periodic ADC conversion scheduler with timeout watch,
// 4-deep first-word fall-through sample FIFO and sticky overrun/timeout flags.
module adc_sample_sched #(
  parameter int DIV_W   = 16,
  parameter int TIMEOUT = 64,
  parameter int DEPTH   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [DIV_W-1:0] period,
  output logic             rx_en,
  input  logic             rx_done_tick,
  input  logic [11:0]      dout,
  output logic [11:0]      smp_data,
  output logic             smp_valid,
  input  logic             smp_ready,
  input  logic             flag_clr,
  output logic             overrun,
  output logic             timeout_err,
  output logic             busy
);

  localparam int PW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, WAIT, CONV} state_t;

  state_t           state;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] reload;
  logic [TW-1:0]    tcnt;
  logic             tick_in_conv;
  logic             timed_out;

  // Periods below 2 are clamped so a slot always spans at least two cycles.
  assign reload       = (period < DIV_W'(2)) ? DIV_W'(1) : period - DIV_W'(1);
  assign tick_in_conv = (state == CONV) && rx_done_tick;
  assign timed_out    = (state == CONV) && !rx_done_tick && (tcnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      tcnt  <= '0;
      rx_en <= 1'b0;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (enable) begin
            state <= CONV;
            cnt   <= reload;
            tcnt  <= '0;
            rx_en <= 1'b1;
            busy  <= 1'b1;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            cnt <= reload;
            if (enable) begin
              state <= CONV;
              tcnt  <= '0;
              rx_en <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt - DIV_W'(1);
          end
        end
        CONV: begin
          // A slot boundary that lands mid-conversion just reloads; that slot is skipped.
          cnt  <= (cnt == '0) ? reload : cnt - DIV_W'(1);
          tcnt <= tcnt + TW'(1);
          if (rx_done_tick || timed_out) begin
            rx_en <= 1'b0;
            tcnt  <= '0;
            if (enable) begin
              state <= WAIT;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          rx_en <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  logic [11:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          full;
  logic          pop;
  logic          do_push;

  assign full      = (count == (PW + 1)'(DEPTH));
  assign smp_valid = (count != '0);
  assign smp_data  = mem[rd_ptr];
  assign pop       = smp_valid && smp_ready;
  // A same-cycle pop frees the slot, so a full FIFO can still take the push.
  assign do_push   = tick_in_conv && (!full || pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= dout;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, pop})
        2'b10:   count <= count + (PW + 1)'(1);
        2'b01:   count <= count - (PW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if (flag_clr)                          overrun <= 1'b0;
      else if (tick_in_conv && full && !pop) overrun <= 1'b1;
      if (flag_clr)       timeout_err <= 1'b0;
      else if (timed_out) timeout_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_adc_sample_sched.sv
// tb/tb_adc_sample_sched.sv - directed self-checking bench for adc_sample_sched.
module tb_adc_sample_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] period = 16'd100;
  logic        rx_en;
  logic        rx_done_tick = 1'b0;
  logic [11:0] dout = 12'h000;
  logic [11:0] smp_data;
  logic        smp_valid;
  logic        smp_ready = 1'b0;
  logic        flag_clr = 1'b0;
  logic        overrun;
  logic        timeout_err;
  logic        busy;

  int n_checks = 0;
  int n_fail = 0;

  adc_sample_sched #(.DIV_W(16), .TIMEOUT(64), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .enable(enable), .period(period), .rx_en(rx_en),
    .rx_done_tick(rx_done_tick), .dout(dout), .smp_data(smp_data), .smp_valid(smp_valid),
    .smp_ready(smp_ready), .flag_clr(flag_clr), .overrun(overrun),
    .timeout_err(timeout_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    rst = 1'b0; enable = 1'b0; rx_done_tick = 1'b0; smp_ready = 1'b0; flag_clr = 1'b0; dout = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
  endtask

  // Receiver model: ticks 'delay' cycles after each rx_en rise; drops enable with the last tick.
  task automatic run_rx(input int nconv, input int delay, input logic [11:0] first);
    int   done_n = 0;
    int   rise_c = -1000;
    int   c = 0;
    logic prev = 1'b0;
    while (c < 2000 && !(done_n == nconv && !busy)) begin
      @(posedge clk); #1; c++;
      rx_done_tick = 1'b0;
      if (rx_en && !prev) rise_c = c;
      if (rx_en && (c - rise_c == delay - 1) && done_n < nconv) begin
        rx_done_tick = 1'b1;
        dout = first + 12'(done_n);
        done_n++;
        if (done_n == nconv) enable = 1'b0;
      end
      prev = rx_en;
    end
    n_checks++; if (busy !== 1'b0 || done_n != nconv) begin n_fail++; $display("FAIL run_rx_done: busy %b ticks %0d required busy 0 ticks %0d", busy, done_n, nconv); end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (rx_en !== 1'b0) begin n_fail++; $display("FAIL reset_rx_en: got %b required 0", rx_en); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b required 0", busy); end
    n_checks++; if (smp_valid !== 1'b0 || smp_data !== 12'h000) begin n_fail++; $display("FAIL reset_fifo: valid %b data %h required 0 000", smp_valid, smp_data); end
    n_checks++; if (overrun !== 1'b0 || timeout_err !== 1'b0) begin n_fail++; $display("FAIL reset_flags: ovr %b tmo %b required 0 0", overrun, timeout_err); end
  endtask

  task automatic test_periodic();
    int   rises[$];
    int   rise_c = -1000;
    logic prev = 1'b0;
    do_reset();
    period = 16'd100; smp_ready = 1'b1; enable = 1'b1;
    for (int c = 1; c <= 245; c++) begin
      @(posedge clk); #1;
      rx_done_tick = 1'b0;
      if (rx_en && !prev) begin rises.push_back(c); rise_c = c; end
      if (c == rise_c + 40) begin
        n_checks++; if (smp_valid !== 1'b1 || smp_data !== 12'hA5C || rx_en !== 1'b0) begin n_fail++; $display("FAIL periodic_sample@%0d: valid %b data %h rx_en %b required 1 a5c 0", c, smp_valid, smp_data, rx_en); end
      end
      if (c == rise_c + 41) begin
        n_checks++; if (smp_valid !== 1'b0) begin n_fail++; $display("FAIL periodic_drain@%0d: valid %b required 0", c, smp_valid); end
      end
      if (rx_en && c - rise_c == 39) begin rx_done_tick = 1'b1; dout = 12'hA5C; end
      prev = rx_en;
    end
    n_checks++;
    if (rises.size() != 3) begin n_fail++; $display("FAIL periodic_rises: got %0d rises required 3", rises.size()); end
    else if (rises[0] != 1 || rises[1] != 101 || rises[2] != 201) begin n_fail++; $display("FAIL periodic_rises: got %0d %0d %0d required 1 101 201", rises[0], rises[1], rises[2]); end
    enable = 1'b0;
  endtask

  task automatic test_overrun();
    logic [11:0] exp_seq [3] = '{12'd2, 12'd3, 12'd4};
    do_reset();
    period = 16'd10; smp_ready = 1'b0; enable = 1'b1;
    run_rx(6, 3, 12'd1);
    n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_flag: got %b required 1", overrun); end
    n_checks++; if (smp_valid !== 1'b1 || smp_data !== 12'd1) begin n_fail++; $display("FAIL overrun_head: valid %b data %h required 1 001", smp_valid, smp_data); end
    smp_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      n_checks++; if (smp_valid !== 1'b1 || smp_data !== exp_seq[k]) begin n_fail++; $display("FAIL overrun_drain%0d: valid %b data %h required 1 %h", k, smp_valid, smp_data, exp_seq[k]); end
    end
    @(posedge clk); #1;
    n_checks++; if (smp_valid !== 1'b0) begin n_fail++; $display("FAIL overrun_empty: valid %b required 0", smp_valid); end
    smp_ready = 1'b0; flag_clr = 1'b1;
    @(posedge clk); #1;
    flag_clr = 1'b0;
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL overrun_clr: got %b required 0", overrun); end
  endtask

  task automatic test_full_push_pop();
    logic [11:0] exp_seq [3] = '{12'd12, 12'd13, 12'd14};
    do_reset();
    period = 16'd10; smp_ready = 1'b0; enable = 1'b1;
    run_rx(4, 3, 12'd10);
    enable = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (rx_en !== 1'b1) begin n_fail++; $display("FAIL fullpp_conv: rx_en %b required 1", rx_en); end
    @(posedge clk); #1;
    n_checks++; if (smp_valid !== 1'b1 || smp_data !== 12'd10) begin n_fail++; $display("FAIL fullpp_head: valid %b data %h required 1 00a", smp_valid, smp_data); end
    rx_done_tick = 1'b1; dout = 12'd14; smp_ready = 1'b1; enable = 1'b0;
    @(posedge clk); #1;
    rx_done_tick = 1'b0;
    n_checks++; if (overrun !== 1'b0 || smp_data !== 12'd11 || busy !== 1'b0) begin n_fail++; $display("FAIL fullpp_accept: ovr %b data %h busy %b required 0 00b 0", overrun, smp_data, busy); end
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      n_checks++; if (smp_valid !== 1'b1 || smp_data !== exp_seq[k]) begin n_fail++; $display("FAIL fullpp_drain%0d: valid %b data %h required 1 %h", k, smp_valid, smp_data, exp_seq[k]); end
    end
    @(posedge clk); #1;
    smp_ready = 1'b0;
    n_checks++; if (smp_valid !== 1'b0) begin n_fail++; $display("FAIL fullpp_empty: valid %b required 0", smp_valid); end
  endtask

  task automatic test_timeout();
    logic bad = 1'b0;
    do_reset();
    period = 16'd100; enable = 1'b1;
    for (int c = 1; c <= 64; c++) begin
      @(posedge clk); #1;
      if (rx_en !== 1'b1) bad = 1'b1;
    end
    n_checks++; if (bad !== 1'b0 || timeout_err !== 1'b0) begin n_fail++; $display("FAIL timeout_hold: dropped %b tmo %b required 0 0", bad, timeout_err); end
    @(posedge clk); #1;
    n_checks++; if (rx_en !== 1'b0 || timeout_err !== 1'b1 || smp_valid !== 1'b0) begin n_fail++; $display("FAIL timeout_abort: rx_en %b tmo %b valid %b required 0 1 0", rx_en, timeout_err, smp_valid); end
    repeat (35) @(posedge clk);
    #1;
    n_checks++; if (rx_en !== 1'b0) begin n_fail++; $display("FAIL timeout_wait: rx_en %b required 0", rx_en); end
    @(posedge clk); #1;
    n_checks++; if (rx_en !== 1'b1) begin n_fail++; $display("FAIL timeout_restart: rx_en %b required 1", rx_en); end
    flag_clr = 1'b1;
    @(posedge clk); #1;
    flag_clr = 1'b0; enable = 1'b0;
    n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL timeout_clr: got %b required 0", timeout_err); end
  endtask

  task automatic test_wait_tick_and_enable_drop();
    do_reset();
    period = 16'd20; enable = 1'b1;
    for (int c = 1; c <= 25; c++) begin
      @(posedge clk); #1;
      rx_done_tick = 1'b0;
      case (c)
        2: begin rx_done_tick = 1'b1; dout = 12'h111; end
        3: begin
          n_checks++; if (smp_valid !== 1'b1 || smp_data !== 12'h111 || rx_en !== 1'b0) begin n_fail++; $display("FAIL drop_first: valid %b data %h rx_en %b required 1 111 0", smp_valid, smp_data, rx_en); end
          smp_ready = 1'b1;
        end
        4: smp_ready = 1'b0;
        5: begin rx_done_tick = 1'b1; dout = 12'h222; end
        6: begin
          n_checks++; if (smp_valid !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL wait_tick_ignored: valid %b busy %b required 0 1", smp_valid, busy); end
        end
        21: begin
          n_checks++; if (rx_en !== 1'b1) begin n_fail++; $display("FAIL drop_rise: rx_en %b required 1", rx_en); end
          enable = 1'b0;
        end
        22: begin
          n_checks++; if (rx_en !== 1'b1) begin n_fail++; $display("FAIL drop_not_cut: rx_en %b required 1", rx_en); end
        end
        24: begin rx_done_tick = 1'b1; dout = 12'h333; end
        25: begin
          n_checks++; if (smp_valid !== 1'b1 || smp_data !== 12'h333 || busy !== 1'b0 || rx_en !== 1'b0) begin n_fail++; $display("FAIL drop_finish: valid %b data %h busy %b rx_en %b required 1 333 0 0", smp_valid, smp_data, busy, rx_en); end
        end
        default: ;
      endcase
    end
  endtask

  task automatic test_reset_mid_conv();
    do_reset();
    period = 16'd10; enable = 1'b1; smp_ready = 1'b0;
    for (int c = 1; c <= 21; c++) begin
      @(posedge clk); #1;
      rx_done_tick = 1'b0;
      if (c == 2) begin rx_done_tick = 1'b1; dout = 12'h0AA; end
      if (c == 12) begin rx_done_tick = 1'b1; dout = 12'h0BB; end
    end
    n_checks++; if (rx_en !== 1'b1 || smp_valid !== 1'b1 || smp_data !== 12'h0AA) begin n_fail++; $display("FAIL rstmid_pre: rx_en %b valid %b data %h required 1 1 0aa", rx_en, smp_valid, smp_data); end
    #2 rst = 1'b0; enable = 1'b0;
    #1;
    n_checks++; if (rx_en !== 1'b0 || busy !== 1'b0 || smp_valid !== 1'b0 || smp_data !== 12'h000 || overrun !== 1'b0 || timeout_err !== 1'b0) begin n_fail++; $display("FAIL rstmid_async: rx_en %b busy %b valid %b data %h ovr %b tmo %b required all 0", rx_en, busy, smp_valid, smp_data, overrun, timeout_err); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (smp_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_release: valid %b busy %b required 0 0", smp_valid, busy); end
  endtask

  initial begin
    test_reset();
    test_periodic();
    test_overrun();
    test_full_push_pop();
    test_timeout();
    test_wait_tick_and_enable_drop();
    test_reset_mid_conv();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
